// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and sizing helpers for the compute-clock enable sequencer.
package clock_gate_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      STOP  = 3'd2,
      GRANT = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_CNT_W        = 32;
   localparam int DEF_DRAIN_CYCLES = 3;

   // Index width for a counter/pointer over n items, never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_PTR_W = ptr_width(DEF_NUM_REQ);

endpackage

// File: rtl/clock_gate_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
   import clock_gate_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PTR_W   = DEF_PTR_W
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   next_ptr,
   output logic               any
);

   logic [PTR_W-1:0] idx_s;
   logic             found_s;

   // Rotating scan; the first hit wins and the pointer moves just past it.
   always_comb begin
      grant    = {NUM_REQ{1'b0}};
      next_ptr = ptr;
      found_s  = 1'b0;
      idx_s    = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_s = PTR_W'((int'(ptr) + i) % NUM_REQ);
         if (!found_s && req[idx_s]) begin
            found_s      = 1'b1;
            grant[idx_s] = 1'b1;
            next_ptr     = PTR_W'((int'(idx_s) + 1) % NUM_REQ);
         end else begin
            found_s = found_s;
         end
      end
      any = found_s;
   end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Clock-enable sequencer for the compute-clock gating buffer: budgeted runs,
// drained pause windows and round-robin ownership of each pause.
module clock_gate_ctrl
   import clock_gate_ctrl_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [CNT_W-1:0]   budget,
   input  logic [NUM_REQ-1:0] pause_req,
   output logic [NUM_REQ-1:0] pause_ack,
   output logic               clock_enable,
   output logic               running,
   output logic               done,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam int PTR_W   = ptr_width(NUM_REQ);
   localparam int DRAIN_W = ptr_width(DRAIN_CYCLES);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   state_e             state_r, state_s;
   logic [CNT_W-1:0]   budget_r, budget_s, count_s;
   logic [DRAIN_W-1:0] drain_r, drain_s;
   logic [PTR_W-1:0]   ptr_r, ptr_s, arb_next_s;
   logic [NUM_REQ-1:0] ack_s, arb_grant_s;
   logic               done_s, arb_any_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req      (pause_req),
      .ptr      (ptr_r),
      .grant    (arb_grant_s),
      .next_ptr (arb_next_s),
      .any      (arb_any_s)
   );

   // Next-state and next-output decode.
   always_comb begin
      state_s  = state_r;
      budget_s = budget_r;
      count_s  = cycle_count;
      drain_s  = drain_r;
      ptr_s    = ptr_r;
      ack_s    = pause_ack;
      done_s   = done;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               budget_s = budget;
               count_s  = {CNT_W{1'b0}};
               if (budget == {CNT_W{1'b0}}) begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s = RUN;
                  done_s  = 1'b0;
               end
            end else if ((state_r == DONE) && (|pause_req)) begin
               state_s = STOP;
            end else begin
               state_s = state_r;
            end
         end
         RUN: begin
            if (clock_enable) begin
               count_s = cycle_count + CNT_W'(1);
            end else begin
               count_s = cycle_count;
            end
            // Budget exhaustion and a pause request share one STOP.
            if (((cycle_count + CNT_W'(1)) == budget_r) || (|pause_req)) begin
               state_s = STOP;
            end else begin
               state_s = RUN;
            end
         end
         STOP: begin
            if (drain_r == DRAIN_LAST) begin
               drain_s = {DRAIN_W{1'b0}};
               if (|pause_req) begin
                  state_s = GRANT;
               end else if (cycle_count == budget_r) begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s = RUN;
               end
            end else begin
               drain_s = drain_r + DRAIN_W'(1);
            end
         end
         GRANT: begin
            // With no owner, this cycle arbitrates; it is also the one idle gap after a release.
            if (|pause_ack) begin
               if ((pause_req & pause_ack) == {NUM_REQ{1'b0}}) begin
                  ack_s = {NUM_REQ{1'b0}};
               end else begin
                  ack_s = pause_ack;
               end
            end else if (arb_any_s) begin
               ack_s = arb_grant_s;
               ptr_s = arb_next_s;
            end else if (cycle_count == budget_r) begin
               state_s = DONE;
               done_s  = 1'b1;
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
            ack_s   = {NUM_REQ{1'b0}};
         end
      endcase
   end

   // State and registered outputs; reset forces the clock off and drops any grant at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         budget_r     <= {CNT_W{1'b0}};
         cycle_count  <= {CNT_W{1'b0}};
         drain_r      <= {DRAIN_W{1'b0}};
         ptr_r        <= {PTR_W{1'b0}};
         pause_ack    <= {NUM_REQ{1'b0}};
         done         <= 1'b0;
         clock_enable <= 1'b0;
         running      <= 1'b0;
      end else begin
         state_r      <= state_s;
         budget_r     <= budget_s;
         cycle_count  <= count_s;
         drain_r      <= drain_s;
         ptr_r        <= ptr_s;
         pause_ack    <= ack_s;
         done         <= done_s;
         clock_enable <= (state_s == RUN);
         running      <= (state_s == RUN);
      end
   end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomized scenario bench for clock_gate_ctrl against a behavioural model.
module tb_clock_gate_ctrl;

   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 32;
   localparam int DRAIN   = 3;

   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic               start = 1'b0;
   logic [CNT_W-1:0]   budget = '0;
   logic [NUM_REQ-1:0] pause_req = '0;
   logic [NUM_REQ-1:0] pause_ack;
   logic               clock_enable, running, done;
   logic [CNT_W-1:0]   cycle_count;

   int checks = 0;
   int errors = 0;
   int ce_cycles = 0;      // enabled cycles seen since the last accepted start
   int since_fall = 1000;  // samples since clock_enable last fell
   int rr_ptr = 0;         // expected round-robin pointer

   always #5 clock = ~clock;

   clock_gate_ctrl #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .budget(budget),
      .pause_req(pause_req), .pause_ack(pause_ack), .clock_enable(clock_enable),
      .running(running), .done(done), .cycle_count(cycle_count)
   );

   function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input int idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      logic ce_before;
      ce_before = clock_enable;
      if (clock_enable) ce_cycles++;
      @(posedge clock); #1;
      if (ce_before && !clock_enable) since_fall = 0;
      else if (!clock_enable && since_fall < 1000) since_fall++;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0; start = 1'b0; pause_req = '0; budget = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      rr_ptr = 0; ce_cycles = 0; since_fall = 1000;
      tick();
   endtask

   task automatic pulse_start(input int b, input bit accepted);
      budget = CNT_W'(b);
      start = 1'b1;
      if (accepted) ce_cycles = 0;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name);
      int n;
      n = 0;
      while (!done && n < limit) begin tick(); n++; end
      checks++;
      if (!done) begin errors++; $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n); end
   endtask

   task automatic wait_ack(input int limit, input string name);
      int n;
      n = 0;
      while (pause_ack == '0 && n < limit) begin tick(); n++; end
      checks++;
      if (pause_ack == '0) begin errors++; $display("FAIL %s_ack_timeout: no grant after %0d cycles", name, n); end
   endtask

   task automatic wait_count(input int c, input int limit);
      int n;
      n = 0;
      while (cycle_count != CNT_W'(c) && n < limit) begin tick(); n++; end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (clock_enable !== 1'b0 || pause_ack !== '0 || running !== 1'b0 || done !== 1'b0 || cycle_count !== '0) begin
         errors++;
         $display("FAIL reset_state: ce=%b ack=%b run=%b done=%b count=%0d, required all zero",
                  clock_enable, pause_ack, running, done, cycle_count);
      end
   endtask

   task automatic test_budget_run();
      int b;
      for (int t = 0; t < 4; t++) begin
         b = (t == 0) ? 10 : int'($urandom_range(1, 30));
         pulse_start(b, 1'b1);
         checks++;
         if (clock_enable !== 1'b1 || running !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL run_launch: ce=%b run=%b done=%b, required 1 1 0", clock_enable, running, done);
         end
         wait_done(b + 20, "run");
         checks++;
         if (ce_cycles != b || cycle_count !== CNT_W'(b)) begin
            errors++; $display("FAIL run_budget: ce_cycles=%0d count=%0d, required %0d", ce_cycles, cycle_count, b);
         end
         checks++;
         if (clock_enable !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL run_end: ce=%b run=%b, required 0 0", clock_enable, running);
         end
      end
   endtask

   task automatic test_single_pause();
      int hold;
      pulse_start(100, 1'b1);
      wait_count(20, 200);
      pause_req[2] = 1'b1;
      tick();
      checks++;
      if (clock_enable !== 1'b0 || cycle_count !== CNT_W'(ce_cycles)) begin
         errors++; $display("FAIL pause_stop: ce=%b count=%0d, required ce=0 count=%0d", clock_enable, cycle_count, ce_cycles);
      end
      wait_ack(20, "pause");
      checks++;
      if (pause_ack !== 4'b0100 || since_fall != DRAIN + 1) begin
         errors++; $display("FAIL pause_grant: ack=%b latency=%0d, required 0100 latency %0d", pause_ack, since_fall, DRAIN + 1);
      end
      rr_ptr = 3;
      hold = int'($urandom_range(1, 5));
      repeat (hold) tick();
      checks++;
      if (pause_ack !== 4'b0100 || clock_enable !== 1'b0) begin
         errors++; $display("FAIL pause_hold: ack=%b ce=%b, required 0100 0", pause_ack, clock_enable);
      end
      pause_req[2] = 1'b0;
      tick();
      checks++;
      if (pause_ack !== '0 || clock_enable !== 1'b0) begin
         errors++; $display("FAIL pause_release: ack=%b ce=%b, required 0000 0", pause_ack, clock_enable);
      end
      tick();
      checks++;
      if (clock_enable !== 1'b1 || pause_ack !== '0) begin
         errors++; $display("FAIL pause_resume: ce=%b ack=%b, required 1 0000", clock_enable, pause_ack);
      end
      wait_done(200, "pause");
      checks++;
      if (cycle_count !== CNT_W'(100) || ce_cycles != 100) begin
         errors++; $display("FAIL pause_total: count=%0d ce_cycles=%0d, required 100", cycle_count, ce_cycles);
      end
   endtask

   task automatic test_multi_grant();
      logic [NUM_REQ-1:0] pending;
      int exp, guard;
      do_reset();
      pulse_start(50, 1'b1);
      wait_count(int'($urandom_range(5, 40)), 100);
      pending = 4'b1011;
      pause_req = pending;
      tick();
      wait_ack(20, "multi");
      checks++;
      if (since_fall != DRAIN + 1) begin
         errors++; $display("FAIL multi_latency: %0d, required %0d", since_fall, DRAIN + 1);
      end
      guard = 0;
      while (pending != '0 && guard < 8) begin
         guard++;
         exp = rr_pick(pending, rr_ptr);
         checks++;
         if (pause_ack !== onehot(exp) || clock_enable !== 1'b0) begin
            errors++; $display("FAIL multi_order: ack=%b ce=%b, required %b 0", pause_ack, clock_enable, onehot(exp));
         end
         rr_ptr = (exp + 1) % NUM_REQ;
         repeat (int'($urandom_range(0, 3))) tick();
         pending[exp] = 1'b0;
         pause_req = pending;
         tick();
         checks++;
         if (pause_ack !== '0 || clock_enable !== 1'b0) begin
            errors++; $display("FAIL multi_gap: ack=%b ce=%b, required 0000 0", pause_ack, clock_enable);
         end
         tick();
      end
      checks++;
      if (clock_enable !== 1'b1 || pause_ack !== '0) begin
         errors++; $display("FAIL multi_resume: ce=%b ack=%b, required 1 0000", clock_enable, pause_ack);
      end
      wait_done(100, "multi");
      checks++;
      if (cycle_count !== CNT_W'(50) || ce_cycles != 50) begin
         errors++; $display("FAIL multi_total: count=%0d ce_cycles=%0d, required 50", cycle_count, ce_cycles);
      end
   endtask

   task automatic test_budget_and_pause();
      int b, r;
      b = int'($urandom_range(5, 30));
      pulse_start(b, 1'b1);
      wait_count(b - 1, 60);
      pause_req[1] = 1'b1;
      tick();
      checks++;
      if (clock_enable !== 1'b0 || cycle_count !== CNT_W'(b)) begin
         errors++; $display("FAIL both_stop: ce=%b count=%0d, required 0 %0d", clock_enable, cycle_count, b);
      end
      wait_ack(20, "both");
      checks++;
      if (pause_ack !== onehot(rr_pick(4'b0010, rr_ptr)) || since_fall != DRAIN + 1) begin
         errors++; $display("FAIL both_grant: ack=%b latency=%0d, required 0010 %0d", pause_ack, since_fall, DRAIN + 1);
      end
      rr_ptr = 2;
      tick();
      pause_req = '0;
      tick();
      tick();
      checks++;
      if (done !== 1'b1 || clock_enable !== 1'b0 || cycle_count !== CNT_W'(b) || ce_cycles != b) begin
         errors++; $display("FAIL both_done: done=%b ce=%b count=%0d ce_cycles=%0d, required 1 0 %0d", done, clock_enable, cycle_count, ce_cycles, b);
      end
      r = int'($urandom_range(0, NUM_REQ - 1));
      pause_req[r] = 1'b1;
      wait_ack(20, "done_pause");
      checks++;
      if (pause_ack !== onehot(rr_pick(onehot(r), rr_ptr)) || done !== 1'b1 || clock_enable !== 1'b0) begin
         errors++; $display("FAIL done_pause_grant: ack=%b done=%b ce=%b, required %b 1 0", pause_ack, done, clock_enable, onehot(r));
      end
      rr_ptr = (r + 1) % NUM_REQ;
      pause_req = '0;
      repeat (6) tick();
      checks++;
      if (done !== 1'b1 || clock_enable !== 1'b0 || cycle_count !== CNT_W'(b) || ce_cycles != b || pause_ack !== '0) begin
         errors++; $display("FAIL done_pause_return: done=%b ce=%b count=%0d ack=%b, required 1 0 %0d 0000", done, clock_enable, cycle_count, pause_ack, b);
      end
   endtask

   task automatic test_zero_and_ignore();
      pulse_start(0, 1'b1);
      checks++;
      if (done !== 1'b1 || clock_enable !== 1'b0 || cycle_count !== '0) begin
         errors++; $display("FAIL zero_budget: done=%b ce=%b count=%0d, required 1 0 0", done, clock_enable, cycle_count);
      end
      repeat (5) tick();
      checks++;
      if (ce_cycles != 0 || done !== 1'b1) begin
         errors++; $display("FAIL zero_hold: ce_cycles=%0d done=%b, required 0 1", ce_cycles, done);
      end
      pulse_start(20, 1'b1);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL start_clears_done: done=%b, required 0", done);
      end
      repeat (5) tick();
      pulse_start(3, 1'b0);
      wait_done(60, "ignore");
      checks++;
      if (cycle_count !== CNT_W'(20) || ce_cycles != 20) begin
         errors++; $display("FAIL start_ignored: count=%0d ce_cycles=%0d, required 20", cycle_count, ce_cycles);
      end
   endtask

   task automatic test_reset_mid_grant();
      int r;
      pulse_start(40, 1'b1);
      repeat (4) tick();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++;
      if (clock_enable !== 1'b0 || running !== 1'b0) begin
         errors++; $display("FAIL reset_mid_run: ce=%b run=%b, required 0 0", clock_enable, running);
      end
      do_reset();
      pulse_start(40, 1'b1);
      wait_count(int'($urandom_range(3, 30)), 60);
      r = int'($urandom_range(0, 2));
      pause_req[r] = 1'b1;
      wait_ack(20, "reset_grant");
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++;
      if (pause_ack !== '0 || clock_enable !== 1'b0) begin
         errors++; $display("FAIL reset_mid_grant: ack=%b ce=%b, required 0000 0", pause_ack, clock_enable);
      end
      pause_req = '0;
      @(negedge clock);
      reset_n = 1'b1;
      rr_ptr = 0; ce_cycles = 0; since_fall = 1000;
      tick();
      checks++;
      if (cycle_count !== '0 || done !== 1'b0 || running !== 1'b0 || pause_ack !== '0 || clock_enable !== 1'b0) begin
         errors++; $display("FAIL reset_release: count=%0d done=%b run=%b ack=%b ce=%b, required all zero", cycle_count, done, running, pause_ack, clock_enable);
      end
      pulse_start(30, 1'b1);
      repeat (3) tick();
      pause_req = 4'b1111;
      wait_ack(20, "ptr");
      checks++;
      if (pause_ack !== onehot(rr_pick(4'b1111, rr_ptr))) begin
         errors++; $display("FAIL reset_pointer: ack=%b, required %b", pause_ack, onehot(rr_pick(4'b1111, rr_ptr)));
      end
      pause_req = '0;
      wait_done(80, "ptr");
      checks++;
      if (cycle_count !== CNT_W'(30) || ce_cycles != 30) begin
         errors++; $display("FAIL reset_rerun: count=%0d ce_cycles=%0d, required 30", cycle_count, ce_cycles);
      end
   endtask

   initial begin
      test_reset();
      test_budget_run();
      test_single_pause();
      test_multi_grant();
      test_budget_and_pause();
      test_zero_and_ignore();
      test_reset_mid_grant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
Sequences the clock-enable input of the glitchless compute-clock gating buffer.
- Runs the gated compute clock for a host-programmed cycle budget.
- Stops the clock when any of N requesters (host DMA, exception handler, memory bridge) asks for a pause.
- Grants the paused window to one requester at a time by round-robin, then resumes.
- Lives in the always-on clock domain, alongside the gating buffer, between the host control registers and the compute grid.

Parameters:
NUM_REQ, 4, number of pause requesters (>=1)
CNT_W, 32, width of cycle budget and cycle counter
DRAIN_CYCLES, 3, always-on cycles after clock_enable falls before the gated clock is guaranteed stopped (sync-CE latency of the buffer), >=1

Ports:
clock  in  1  always-on (ungated) clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: launch a run
budget  in  CNT_W  number of gated cycles to run; sampled on start
pause_req  in  NUM_REQ  level request per requester to stop the compute clock
pause_ack  out  NUM_REQ  one-hot grant: clock stopped and window owned
clock_enable  out  1  registered CE to the gating buffer
running  out  1  high in RUN state
done  out  1  budget exhausted, held until next start
cycle_count  out  CNT_W  gated cycles delivered in the current run

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release): state IDLE; clock_enable=0; pause_ack=0; running=0; done=0; cycle_count=0; round-robin pointer=0; drain counter=0.
- States: IDLE, RUN, STOP, GRANT, DONE.
- IDLE/DONE, on start:
  - Latch budget and clear cycle_count and done.
  - budget==0 → DONE, with done=1 the next cycle.
  - Otherwise → RUN, with clock_enable=1 from the next cycle.
- start in RUN/STOP/GRANT: ignored; no effect on budget or counters.
- RUN:
  - cycle_count increments on every cycle in which clock_enable==1.
  - If cycle_count+1==budget, or any pause_req bit is high → STOP. clock_enable drops on the same edge on which the last count increments.
  - Budget hit and pause in the same cycle: a single STOP covers both.
- STOP:
  - clock_enable=0; count DRAIN_CYCLES cycles.
  - Then:
    - Any pause_req high → GRANT.
    - Else, if cycle_count==budget → DONE.
    - Else → RUN (a request withdrawn during drain causes no grant).
- GRANT:
  - Round-robin selection: the first requester with pause_req high, searching upward from the pointer and wrapping at NUM_REQ-1.
  - pause_ack for the selected requester is asserted one cycle after entry.
  - The pointer updates to selected+1 (mod NUM_REQ).
  - pause_ack holds while that requester's pause_req stays high. pause_req is never ignored mid-grant.
  - When the owner drops its request, pause_ack falls on the next edge. Exactly one idle cycle follows with pause_ack=0, then:
    - Another request pending → grant the next requester per round-robin.
    - Else, if cycle_count==budget → DONE.
    - Else → RUN. clock_enable rises with no further drain, because the buffer's enable is glitchless.
- DONE: done=1, clock_enable=0. pause_req is still serviced: DONE → STOP → GRANT → back to DONE, with cycle_count unchanged.
- Invariants:
  - pause_ack is always zero or one-hot.
  - pause_ack is never high while clock_enable=1, nor within DRAIN_CYCLES of clock_enable falling.
  - cycle_count never exceeds budget and never wraps.
- Reset asserted mid-run: clock_enable=0 and pause_ack=0 immediately (asynchronously). No pending state survives reset.

Decomposition:
- Package clock_gate_ctrl_pkg: state enum (IDLE, RUN, STOP, GRANT, DONE), default constants for DRAIN_CYCLES and CNT_W, and a localparam for the pointer width $clog2(NUM_REQ) (min 1).
- Sub-module: rr_arbiter. Inputs are req vector and pointer; outputs are one-hot grant and next pointer. It is purely combinational and is used by the GRANT state.

Test Plan:
- Reset, then start with budget=10, no requests → clock_enable high for exactly 10 cycles; cycle_count=10; done=1; running low after.
- Run budget=100; raise pause_req[2] at count 20 → clock_enable drops; pause_ack[2] not before 3 drain cycles plus 1. Drop req → ack falls, then clock resumes. Final cycle_count=100.
- Run budget=50; raise pause_req[0], [1], [3] together → acks granted in order 0, 1, 3, each one-hot, with a gap cycle between. Clock stays off throughout, then resumes once.
- Budget expiry and pause_req[1] in the same cycle → single STOP, grant to 1, then DONE; cycle_count=budget exactly.
- start with budget=0 → DONE next cycle; clock_enable never rises. start during RUN → ignored, budget unchanged.
- Assert reset_n low mid-GRANT → pause_ack and clock_enable go to 0 immediately. After release: state IDLE, pointer=0, cycle_count=0.
